// File: rtl/snake_pkg.sv
// Shared snake-game constants: playfield size, coordinate widths and the
// target_manager state encoding.
package snake_pkg;

   localparam int GRID_W = 160;
   localparam int GRID_H = 120;
   localparam int X_W    = 8;
   localparam int Y_W    = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      CHECK  = 2'd2,
      QUERY  = 2'd3
   } tm_state_t;

endpackage

// File: rtl/target_manager.sv
// Food target holder: detects the head eating the target, then searches the
// random generator for a legal, unoccupied cell and publishes it.
module target_manager
   import snake_pkg::*;
#(
   parameter int MAX_X     = GRID_W,
   parameter int MAX_Y     = GRID_H,
   parameter int INIT_X    = 40,
   parameter int INIT_Y    = 30,
   parameter int MAX_TRIES = 16
) (
   input  logic           CLK,
   input  logic           RESET,
   input  logic [X_W-1:0] RAND_X,
   input  logic [Y_W-1:0] RAND_Y,
   input  logic [X_W-1:0] HEAD_X,
   input  logic [Y_W-1:0] HEAD_Y,
   input  logic           HEAD_VALID,
   output logic           BODY_REQ,
   output logic [X_W-1:0] BODY_X,
   output logic [Y_W-1:0] BODY_Y,
   input  logic           BODY_ACK,
   input  logic           BODY_HIT,
   output logic [X_W-1:0] TARGET_X,
   output logic [Y_W-1:0] TARGET_Y,
   output logic           TARGET_VALID,
   output logic           TARGET_REACHED,
   output logic [7:0]     SCORE
);

   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   // One extra bit so a limit equal to 2**width still compares correctly.
   localparam logic [X_W:0]       LIM_X    = (X_W+1)'(MAX_X);
   localparam logic [Y_W:0]       LIM_Y    = (Y_W+1)'(MAX_Y);
   localparam logic [X_W-1:0]     FB_X     = X_W'(INIT_X);
   localparam logic [Y_W-1:0]     FB_Y     = Y_W'(INIT_Y);
   localparam logic [TRY_W-1:0]   LAST_TRY = TRY_W'(MAX_TRIES - 1);
   localparam logic [TRY_W-1:0]   TRY_ONE  = TRY_W'(1);

   tm_state_t        state;
   logic [X_W-1:0]   cand_x;
   logic [Y_W-1:0]   cand_y;
   logic [TRY_W-1:0] tries;

   logic head_on_target;
   logic cand_in_range;
   logic reject;

   assign head_on_target = HEAD_VALID && (HEAD_X == TARGET_X) && (HEAD_Y == TARGET_Y);
   assign cand_in_range  = ({1'b0, cand_x} < LIM_X) && ({1'b0, cand_y} < LIM_Y);

   // A candidate dies either at the range check or on an occupied-cell answer.
   assign reject = ((state == CHECK) && !cand_in_range) ||
                   ((state == QUERY) && BODY_ACK && BODY_HIT);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state          <= IDLE;
         cand_x         <= '0;
         cand_y         <= '0;
         tries          <= '0;
         BODY_REQ       <= 1'b0;
         BODY_X         <= '0;
         BODY_Y         <= '0;
         TARGET_X       <= FB_X;
         TARGET_Y       <= FB_Y;
         TARGET_VALID   <= 1'b1;
         TARGET_REACHED <= 1'b0;
         SCORE          <= '0;
      end else begin
         TARGET_REACHED <= 1'b0;

         case (state)
            IDLE: begin
               if (head_on_target) begin
                  TARGET_REACHED <= 1'b1;
                  TARGET_VALID   <= 1'b0;
                  if (SCORE != 8'hFF)
                     SCORE <= SCORE + 8'd1;
                  tries <= '0;
                  state <= SAMPLE;
               end
            end

            SAMPLE: begin
               cand_x <= RAND_X;
               cand_y <= RAND_Y;
               state  <= CHECK;
            end

            CHECK: begin
               if (cand_in_range) begin
                  BODY_X   <= cand_x;
                  BODY_Y   <= cand_y;
                  BODY_REQ <= 1'b1;
                  state    <= QUERY;
               end
            end

            QUERY: begin
               if (BODY_ACK) begin
                  BODY_REQ <= 1'b0;
                  if (!BODY_HIT) begin
                     TARGET_X     <= cand_x;
                     TARGET_Y     <= cand_y;
                     TARGET_VALID <= 1'b1;
                     state        <= IDLE;
                  end
               end
            end

            default: state <= IDLE;
         endcase

         // Out of retries: fall back to the start cell without asking the body.
         if (reject) begin
            if (tries == LAST_TRY) begin
               TARGET_X     <= FB_X;
               TARGET_Y     <= FB_Y;
               TARGET_VALID <= 1'b1;
               state        <= IDLE;
            end else begin
               tries <= tries + TRY_ONE;
               state <= SAMPLE;
            end
         end
      end
   end

endmodule

// File: doc/target_manager.md
# target_manager

Holds the snake's current food target and decides when it has been eaten. When a head move lands on the target, it pulses a "target reached" strobe and samples the free-running random coordinate generator. It range-checks each candidate and asks the snake body store whether the cell is occupied, repeating until a legal cell is found, then publishes a new stable target. It sits directly downstream of the random target generator and feeds the VGA/drawing logic and the score display.

## Interface
Parameters:
- MAX_X, 160, grid width; legal X is 0..MAX_X-1
- MAX_Y, 120, grid height; legal Y is 0..MAX_Y-1
- INIT_X, 40, target X after reset and fallback X
- INIT_Y, 30, target Y after reset and fallback Y
- MAX_TRIES, 16, rejected candidates allowed before the fallback is used

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- RAND_X  in  8  free-running random X; changes every cycle
- RAND_Y  in  7  free-running random Y; changes every cycle
- HEAD_X  in  8  snake head X
- HEAD_Y  in  7  snake head Y
- HEAD_VALID  in  1  one-cycle pulse: head has moved to HEAD_X/HEAD_Y
- BODY_REQ  out  1  occupancy query request, held until acknowledged
- BODY_X  out  8  query X, stable while BODY_REQ=1
- BODY_Y  out  7  query Y, stable while BODY_REQ=1
- BODY_ACK  in  1  query answered this cycle
- BODY_HIT  in  1  qualified by BODY_ACK: the cell is occupied by the body
- TARGET_X  out  8  current target X
- TARGET_Y  out  7  current target Y
- TARGET_VALID  out  1  target is stable and drawable
- TARGET_REACHED  out  1  one-cycle pulse: target eaten
- SCORE  out  8  targets eaten, saturating

## Operation
- All outputs are registered.
- Reset values:
  - TARGET_X=INIT_X, TARGET_Y=INIT_Y, TARGET_VALID=1
  - TARGET_REACHED=0, BODY_REQ=0, BODY_X=0, BODY_Y=0, SCORE=0
  - state IDLE, try counter 0
- IDLE: when HEAD_VALID=1, HEAD_X=TARGET_X and HEAD_Y=TARGET_Y:
  - TARGET_REACHED<=1 for exactly one cycle, TARGET_VALID<=0
  - SCORE increments; it stays at 255 once there
  - try counter<=0; go to SAMPLE
- HEAD_VALID outside IDLE is ignored. No second strobe and no score change.
- SAMPLE: candidate<=RAND_X/RAND_Y; go to CHECK.
- CHECK:
  - if candidate X<MAX_X and Y<MAX_Y: load BODY_X/BODY_Y with the candidate, BODY_REQ<=1, go to QUERY
  - otherwise the candidate is rejected (see reject rule)
- QUERY: BODY_REQ stays 1 until BODY_ACK=1 is sampled; BODY_REQ<=0 on that edge.
  - BODY_HIT=0: commit TARGET<=candidate, TARGET_VALID<=1, go to IDLE
  - BODY_HIT=1: reject the candidate
- Reject rule:
  - try counter+1 = MAX_TRIES: commit INIT_X/INIT_Y without a body query, TARGET_VALID<=1, go to IDLE
  - otherwise increment the try counter and go to SAMPLE
- BODY_ACK while BODY_REQ=0 is ignored.
- Comparisons are unsigned at the full port widths. The try counter is $clog2(MAX_TRIES+1) bits.

## Timing
- HEAD_VALID match sampled at edge n:
  - TARGET_REACHED=1 and TARGET_VALID=0 during cycle n+1
  - candidate captured at edge n+1
  - CHECK at edge n+2
  - BODY_REQ=1 from edge n+2
- Ack in the same cycle BODY_REQ rises (ack seen at edge n+3), no hit: new target and TARGET_VALID=1 from edge n+3.
- Each out-of-range candidate costs 2 cycles. Each body hit costs 2 cycles plus the ack wait.
- TARGET_X/TARGET_Y change only while TARGET_VALID=0.
- RESET mid-query: BODY_REQ drops at the reset edge, and all registers take their reset values on that same edge.

## Structure
- Shared snake_pkg holds:
  - GRID_W=160 and GRID_H=120
  - coordinate width constants (X 8 bits, Y 7 bits)
  - the state enum IDLE/SAMPLE/CHECK/QUERY
- Single module with no sub-module. The range check and head compare are small inline comparators.

## Test plan
- Reset, then HEAD_VALID with head (40,30) and BODY_ACK tied to BODY_REQ, BODY_HIT=0, RAND=(100,50) held → TARGET_REACHED one cycle, SCORE=1, target (100,50), TARGET_VALID=1 three cycles after the match.
- RAND=(200,50) for 2 cycles, then (10,10) → first candidate rejected with no BODY_REQ; target (10,10) committed.
- RAND=(5,125), then (5,119) → Y=125 rejected; (5,119) accepted (boundary MAX_Y-1).
- BODY_HIT=1 on every ack with valid RAND → after 16 rejections target=(40,30), TARGET_VALID=1, BODY_REQ=0.
- BODY_ACK delayed 5 cycles → BODY_REQ, BODY_X and BODY_Y stable throughout; HEAD_VALID matching the old target during the wait → no extra TARGET_REACHED, SCORE unchanged.
- RESET asserted while BODY_REQ=1 → next cycle BODY_REQ=0, target (40,30), TARGET_VALID=1, SCORE=0. Also 256 eats → SCORE stays 255.
